// File: rtl/aclk_pkg.sv
// Shared key codes, FSM state encodings, alarm-time payload and BCD time check
// for the alarm-clock entry block.
package aclk_pkg;

   localparam int unsigned DIGIT_W             = 4;
   localparam int unsigned STATE_W             = 2;
   localparam int unsigned TIMEOUT_SEC_DEFAULT = 10;

   localparam logic [DIGIT_W-1:0] KEY_ALARM = 4'hA;
   localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hC;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ENTRY = 2'd1;
   localparam state_t ST_LOAD  = 2'd2;

   typedef struct packed {
      logic [DIGIT_W-1:0] ms_hr;
      logic [DIGIT_W-1:0] ls_hr;
      logic [DIGIT_W-1:0] ms_min;
      logic [DIGIT_W-1:0] ls_min;
   } alarm_time_t;

   // 24-hour HH:MM sanity check on the four BCD digits
   function automatic logic time_valid(input alarm_time_t t);
      return (t.ms_hr <= 4'd2) && (t.ls_hr <= 4'd9) &&
             !((t.ms_hr == 4'd2) && (t.ls_hr > 4'd3)) &&
             (t.ms_min <= 4'd5) && (t.ls_min <= 4'd9);
   endfunction

endpackage

// File: rtl/aclk_entry_timer.sv
// Inactivity timer for alarm entry: counts enabled ticks and flags the tick
// that would reach TIMEOUT_SEC; clear has priority over counting.
module aclk_entry_timer
   import aclk_pkg::*;
#(
   parameter int unsigned TIMEOUT_SEC = TIMEOUT_SEC_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic tick,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_SEC - 1);

   logic [CNT_W-1:0] count_q;

   // Expiry is flagged on the tick itself so the FSM can leave in the same cycle
   assign expired = enable && tick && (count_q == LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable && tick) begin
         count_q <= expired ? '0 : count_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/auto_alarm_entry.sv
// Keypad alarm-time entry FSM (IDLE/ENTRY/LOAD) with inactivity timeout.
// Define ACLK_ENTRY_VALIDATE_EN to reject out-of-range times with entry_error.
module auto_alarm_entry
   import aclk_pkg::*;
#(
   parameter int unsigned TIMEOUT_SEC = TIMEOUT_SEC_DEFAULT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       one_second,
   input  logic       key_valid,
   input  logic [3:0] key,
   output logic [3:0] new_alarm_ms_hr,
   output logic [3:0] new_alarm_ls_hr,
   output logic [3:0] new_alarm_ms_min,
   output logic [3:0] new_alarm_ls_min,
   output logic       load_new_alarm,
   output logic       entry_active,
   output logic       entry_error
);

   state_t      state_q, state_d;
   alarm_time_t digits_q, digits_d;
   logic        error_d;
   logic        timer_clear_c;
   logic        timer_enable_c;
   logic        expired_c;
   logic        is_digit_c;
   logic        time_ok_c;

   assign is_digit_c     = (key <= 4'd9);
   assign timer_enable_c = (state_q == ST_ENTRY);

`ifdef ACLK_ENTRY_VALIDATE_EN
   assign time_ok_c = time_valid(digits_q);
`else
   assign time_ok_c = 1'b1;
`endif

   aclk_entry_timer #(
      .TIMEOUT_SEC (TIMEOUT_SEC)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (timer_clear_c),
      .enable  (timer_enable_c),
      .tick    (one_second),
      .expired (expired_c)
   );

   // Next-state, digit shifter and timer restart; a key beats a same-cycle expiry
   always_comb begin
      state_d       = state_q;
      digits_d      = digits_q;
      error_d       = 1'b0;
      timer_clear_c = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (key_valid && is_digit_c) begin
               digits_d        = '0;
               digits_d.ls_min = key;
               state_d         = ST_ENTRY;
            end
         end
         ST_ENTRY: begin
            timer_clear_c = 1'b0;
            if (key_valid && is_digit_c) begin
               digits_d.ms_hr  = digits_q.ls_hr;
               digits_d.ls_hr  = digits_q.ms_min;
               digits_d.ms_min = digits_q.ls_min;
               digits_d.ls_min = key;
               timer_clear_c   = 1'b1;
            end else if (key_valid && (key == KEY_CLEAR)) begin
               digits_d      = '0;
               timer_clear_c = 1'b1;
            end else if (key_valid && (key == KEY_ALARM)) begin
               timer_clear_c = 1'b1;
               if (time_ok_c) begin
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_IDLE;
                  error_d = 1'b1;
               end
            end else if (expired_c) begin
               state_d  = ST_IDLE;
               digits_d = '0;
            end
         end
         ST_LOAD: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status outputs are registered from the next state so they align with it
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         digits_q       <= '0;
         load_new_alarm <= 1'b0;
         entry_active   <= 1'b0;
         entry_error    <= 1'b0;
      end else begin
         state_q        <= state_d;
         digits_q       <= digits_d;
         load_new_alarm <= (state_d == ST_LOAD);
         entry_active   <= (state_d == ST_ENTRY);
         entry_error    <= error_d;
      end
   end

   assign new_alarm_ms_hr  = digits_q.ms_hr;
   assign new_alarm_ls_hr  = digits_q.ls_hr;
   assign new_alarm_ms_min = digits_q.ms_min;
   assign new_alarm_ls_min = digits_q.ls_min;

endmodule
